// File: rtl/mpmc11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_pkg
// Brief    : Shared controller and strip-sequencer state encodings.
// Revision : 1.0
// ============================================================================
package mpmc11_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WRITE_CMD  = 3'd1,
      WRITE_DATA = 3'd2,
      READ_CMD   = 3'd3,
      READ_DATA0 = 3'd4,
      READ_DATA1 = 3'd5,
      READ_DATA2 = 3'd6,
      READ_DATA3 = 3'd7
   } mpmc11_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mpmc11_strip_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mpmc11_strip_idx_gen.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_strip_idx_gen
// Brief    : Initial and next strip index for linear or wrapping bursts.
// Revision : 1.0
// ============================================================================
module mpmc11_strip_idx_gen #(
   parameter int W = 8
) (
   input  logic         load,
   input  logic [W-1:0] start_strip,
   input  logic [W-1:0] num_strips,
   input  logic [W-1:0] cur_idx,
   input  logic         wrap,
   output logic [W-1:0] next_idx
);

   localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

   always_comb begin
      next_idx = cur_idx + c_ONE;
      if (load) begin
         // A wrapping burst cannot start outside its own window.
         next_idx = (wrap && (start_strip > num_strips)) ? '0 : start_strip;
      end else if (wrap && (cur_idx == num_strips)) begin
         next_idx = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mpmc11_resp_strip_seq.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_resp_strip_seq
// Brief    : Read-response strip sequencer: counts beats, tracks strip index.
// Revision : 1.0
// ============================================================================
module mpmc11_resp_strip_seq
   import mpmc11_pkg::*;
#(
   parameter int W       = 8,
   parameter int WRAP_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  mpmc11_state_t state,
   input  logic          valid,
   input  logic [W-1:0]  num_strips,
   input  logic [W-1:0]  start_strip,
   input  logic          wrap,
   output logic [W-1:0]  strip_cnt,
   output logic [W-1:0]  strip_idx,
   output logic          first,
   output logic          last,
   output logic          busy,
   output logic          done,
   output logic          overrun
);

   localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

   mpmc11_strip_seq_state_t seq_state_q, seq_state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] idx_q, idx_d;
   logic [W-1:0] num_q, num_d;
   logic         wrap_q, wrap_d;
   logic         done_q, done_d;
   logic         overrun_q, overrun_d;

   logic         w_wrap_in;
   logic         w_load;
   logic         w_at_last;
   logic [W-1:0] w_gen_num;
   logic         w_gen_wrap;
   logic [W-1:0] w_next_idx;

   generate
      if (WRAP_EN != 0) begin : g_wrap_en
         assign w_wrap_in = wrap;
      end else begin : g_wrap_dis
         logic w_unused_wrap;
         assign w_unused_wrap = wrap;
         assign w_wrap_in     = 1'b0;
      end
   endgenerate

   assign w_load     = (seq_state_q == S_IDLE) && (state == READ_DATA0);
   assign w_at_last  = (cnt_q == num_q);
   assign w_gen_num  = w_load ? num_strips : num_q;
   assign w_gen_wrap = w_load ? w_wrap_in  : wrap_q;

   mpmc11_strip_idx_gen #(
      .W (W)
   ) u_idx_gen (
      .load        (w_load),
      .start_strip (start_strip),
      .num_strips  (w_gen_num),
      .cur_idx     (idx_q),
      .wrap        (w_gen_wrap),
      .next_idx    (w_next_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         seq_state_q <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         num_q       <= '0;
         wrap_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         seq_state_q <= seq_state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         num_q       <= num_d;
         wrap_q      <= wrap_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      seq_state_d = seq_state_q;
      if (state == IDLE) begin
         seq_state_d = S_IDLE;
      end else begin
         case (seq_state_q)
            S_IDLE:  if (w_load) seq_state_d = S_RUN;
            S_RUN:   if (valid && w_at_last) seq_state_d = S_DONE;
            S_DONE:  seq_state_d = S_DONE;
            default: seq_state_d = S_IDLE;
         endcase
      end
   end

   // Returning to controller IDLE wins over any beat in the same cycle.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      num_d     = num_q;
      wrap_d    = wrap_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      if (state == IDLE) begin
         cnt_d     = '0;
         overrun_d = 1'b0;
      end else begin
         case (seq_state_q)
            S_IDLE: begin
               if (w_load) begin
                  num_d  = num_strips;
                  wrap_d = w_wrap_in;
                  cnt_d  = '0;
                  idx_d  = w_next_idx;
               end
            end
            S_RUN: begin
               if (valid) begin
                  if (w_at_last) begin
                     done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + c_ONE;
                     idx_d = w_next_idx;
                  end
               end
            end
            S_DONE: begin
               if (valid) overrun_d = 1'b1;
            end
            default: begin
               cnt_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      busy      = (seq_state_q == S_RUN);
      first     = busy && (cnt_q == '0);
      last      = busy && w_at_last;
      strip_cnt = cnt_q;
      strip_idx = idx_q;
      done      = done_q;
      overrun   = overrun_q;
   end

endmodule
`default_nettype wire

// File: doc/mpmc11_resp_strip_seq.md
MPMC11_RESP_STRIP_SEQ -- requirements
Module: mpmc11_resp_strip_seq

Interface
REQ-001 Parameter W, default 8, SHALL set the width of strip counts and indices.
REQ-002 Parameter WRAP_EN, default 1, SHALL enable wrap-mode hardware; when 0, wrap SHALL be ignored (treated as 0).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 state  in  mpmc11_state_t  controller state; IDLE and READ_DATA0 SHALL be decoded.
REQ-007 valid  in  1  response beat valid from the memory read path.
REQ-008 num_strips  in  W  last strip index of the burst; beats = num_strips+1.
REQ-009 start_strip  in  W  first strip index (critical-strip-first).
REQ-010 wrap  in  1  1 = indices wrap within 0..num_strips; 0 = linear.
REQ-011 strip_cnt  out  W  number of beats accepted so far, excluding the final beat.
REQ-012 strip_idx  out  W  strip index of the current beat.
REQ-013 first, last  out  1  current expected beat is the first / final beat.
REQ-014 busy  out  1  sequencer is in S_RUN.
REQ-015 done  out  1  one-cycle pulse after the final beat is accepted.
REQ-016 overrun  out  1  sticky flag: valid seen after completion.

Function
REQ-017 The FSM SHALL have three states: S_IDLE, S_RUN and S_DONE.
REQ-018 When state==IDLE, the FSM SHALL go to S_IDLE and clear strip_cnt, overrun and done, overriding all other events in that cycle, including valid.
REQ-019 In S_IDLE with state==READ_DATA0, the FSM SHALL go to S_RUN and latch num_strips, start_strip and wrap; valid in that same cycle SHALL be ignored.
REQ-020 Latched values SHALL be used for the whole burst; input changes during S_RUN SHALL have no effect.
REQ-021 In S_RUN, valid with strip_cnt != latched num_strips SHALL increment strip_cnt by 1 and advance strip_idx.
REQ-022 In S_RUN, valid with strip_cnt == latched num_strips SHALL leave strip_cnt unchanged, go to S_DONE and assert done for the next cycle only.
REQ-023 num_strips==0 SHALL give a one-beat burst; num_strips==2^W-1 SHALL give 2^W beats with no counter overflow.
REQ-024 In linear mode, strip_idx SHALL start at start_strip and advance as +1 modulo 2^W.
REQ-025 In wrap mode, strip_idx SHALL advance as +1 and return to 0 after the latched num_strips; start_strip > num_strips SHALL start at 0.
REQ-026 first SHALL equal busy && strip_cnt==0; last SHALL equal busy && strip_cnt==latched num_strips.
REQ-027 S_DONE SHALL hold strip_cnt and strip_idx until state==IDLE; valid in S_DONE SHALL set overrun.
REQ-028 All outputs SHALL be registered or decoded only from registered state, with no combinational path from inputs.

Reset
REQ-029 rst SHALL force S_IDLE, strip_cnt=0, strip_idx=0, done=0, overrun=0 and clear the latched registers.
REQ-030 rst asserted mid-burst SHALL abort the burst without a done pulse; rst SHALL take priority over state and valid.

Structure
REQ-031 The FSM state typedef mpmc11_strip_seq_state_t SHALL be added to mpmc11_pkg, next to mpmc11_state_t.
REQ-032 Index stepping (linear/wrap next-index logic) SHALL be one sub-module, mpmc11_strip_idx_gen, parameterised by W.
REQ-033 The block SHALL be usable as a drop-in replacement for the existing strip counter, with W=8, wrap=0 and start_strip=0.

Verification
REQ-034 W=8, num_strips=3, start=0, wrap=0, valid every cycle after READ_DATA0 -> strip_cnt 0,1,2,3,3; done on the cycle after the 4th beat; busy low after it.
REQ-035 num_strips=3, start=2, wrap=1 -> strip_idx sequence 2,3,0,1; first on beat 1; last on beat 4.
REQ-036 num_strips=0 -> single beat; done 1 cycle later; strip_cnt stays 0.
REQ-037 Burst complete, then 2 extra valids -> overrun=1 and strip_cnt unchanged; state=IDLE -> overrun=0.
REQ-038 rst at the 2nd beat of a num_strips=7 burst -> all outputs 0, no done; a new READ_DATA0 burst completes normally.
REQ-039 W=4, num_strips=15, wrap=0, start=15 -> strip_idx 15,0,1..14 across 16 beats; strip_cnt ends at 15; no overflow.
